timer_cfg_sequencer: RTL and testbench
======================================

Name: timer_cfg_sequencer

Overview:
Avalon-MM master sequencer that owns the system interval timer. It programs the timer's period and control registers from a simple command interface, services the timer IRQ by reading and clearing status, and counts timeouts. After a requested number of timeouts it stops the timer. It sits between the tick-scheduling logic (host side) and the timer slave, which has a 16-bit data bus, 3-bit word address and no waitrequest.

Parameters:
CNT_W, 16, width of the timeout-count request and the tick counter
MIN_PERIOD, 32'd1, a cmd_period below this value is clamped to it

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  start request
cmd_ready  out  1  high only in IDLE
cmd_period  in  32  timer period, loaded as {PH,PL}
cmd_count  in  CNT_W  timeouts before auto-stop; 0 = run until cmd_stop
cmd_stop  in  1  single-cycle stop request
busy  out  1  high in any state other than IDLE
tick  out  1  1-cycle pulse per confirmed timeout
done  out  1  1-cycle pulse when the stop write completes
tick_count  out  CNT_W  timeouts since the last accepted command; wraps
avm_address  out  3  timer word address
avm_chipselect  out  1  bus access strobe
avm_write_n  out  1  active-low write
avm_writedata  out  16  write data
avm_readdata  in  16  timer readdata, valid 1 cycle after a read is issued
timer_irq  in  1  timer interrupt, level

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - FSM = IDLE, cmd_ready = 1, busy = 0.
  - tick = 0, done = 0, tick_count = 0.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0.
  - Stop latch and captured count/period are cleared.
- Reset mid-operation: the FSM aborts and the bus goes idle. The timer is not restored; the next command reprograms it completely.
- All avm_* outputs are registered. Each bus access lasts exactly 1 cycle with chipselect = 1. The bus is idle (chipselect = 0) in every other state.
- FSM states:
  - IDLE: on cmd_valid, capture period (clamped) and count, clear tick_count, go to WR_PL.
  - WR_PL: write addr 2 with period[15:0].
  - WR_PH: write addr 3 with period[31:16].
  - WR_CTRL: write addr 1 with 16'h0007 (START | CONT | ITO).
  - RUN: wait. If timer_irq, go to RD_STAT. Else, if the stop latch is set, go to WR_STOP.
  - RD_STAT: read addr 0 (chipselect = 1, write_n = 1).
  - WAIT_RD: sample avm_readdata[0]. If 1, go to CLR_STAT. If 0 (spurious IRQ), return to RUN with no tick.
  - CLR_STAT: write addr 0 with 16'h0000. Pulse tick and increment tick_count. If cmd_count ≠ 0 and the new tick_count == cmd_count, go to WR_STOP. Else, if the stop latch is set, go to WR_STOP. Else go to RUN.
  - WR_STOP: write addr 1 with 16'h0008 (STOP, ITO = 0). Next state DONE.
  - DONE: pulse done, clear the stop latch, go to IDLE.
- Latency: the control write occurs in the 3rd cycle after the cmd_valid&cmd_ready cycle. IRQ-to-tick is 3 cycles (RD_STAT, WAIT_RD, CLR_STAT).
- cmd_stop handling:
  - Latched in any busy state; ignored in IDLE.
  - A stop that arrives during WR_PL/WR_PH/WR_CTRL takes effect from RUN, after programming finishes.
  - If the stop latch and timer_irq are both active in RUN, the IRQ is serviced first (the tick is counted), then the FSM goes to WR_STOP.
- tick_count wraps modulo 2^CNT_W when cmd_count = 0.
- cmd_valid outside IDLE is ignored; no queueing.

Optional Feature:
TIMER_SNAPSHOT_EN
- Defined:
  - Adds input snap_req (1-cycle pulse) and outputs snap_value[31:0] (reset 0) and snap_valid (1-cycle pulse).
  - A request is latched while busy and serviced from RUN, with lower priority than timer_irq and higher than stop.
  - Sequence: write addr 4 (data 0), read addr 4, read addr 5. Capture readdata 1 cycle after each read. Pulse snap_valid together with the final capture, then return to RUN.
  - snap_req while IDLE is dropped.
- Undefined: ports absent, snapshot states absent.

Decomposition:
- Package timer_seq_pkg holds:
  - address constants TMR_STATUS = 0, TMR_CONTROL = 1, TMR_PERIODL = 2, TMR_PERIODH = 3, TMR_SNAPL = 4, TMR_SNAPH = 5.
  - control bit constants CTRL_ITO = 0, CTRL_CONT = 1, CTRL_START = 2, CTRL_STOP = 3.
  - the FSM state enum typedef.
- Sub-module timer_bus_master: a registered single-access Avalon driver (issue write/read, return readdata_valid one cycle later). The FSM stays in the top level.

Test Plan:
1. Reset, then cmd_period = 32'h0001_0005, cmd_count = 0 -> writes (2, 0x0005), (3, 0x0001), (1, 0x0007) on consecutive cycles, cycles 1–3 after acceptance; busy = 1, cmd_ready = 0.
2. cmd_period = 9, cmd_count = 3 with a timer model -> exactly 3 tick pulses, each followed by a write (0, 0x0000); then write (1, 0x0008); done pulses once; tick_count = 3; back to IDLE.
3. timer_irq asserted with status readdata = 0 -> no tick, no status write, FSM returns to RUN, tick_count unchanged.
4. cmd_stop asserted during WR_PH -> the control write 0x0007 still occurs, then write (1, 0x0008) and done; tick_count = 0.
5. cmd_stop and timer_irq in the same RUN cycle -> status read, clear and tick happen first, then the stop write; tick_count incremented by 1.
6. reset asserted in WAIT_RD -> next cycle chipselect = 0, cmd_ready = 1, tick_count = 0; a new command reprograms all three registers. With TIMER_SNAPSHOT_EN: snap_req in RUN with timer snapshot 0x0000_0042 -> snap_value = 32'h42, snap_valid pulses once.

Source files
------------

// File: rtl/timer_cfg_sequencer_pkg.sv
// timer_seq_pkg: timer register map, control bits, FSM encoding, bus request.
// TIMER_SNAPSHOT_EN adds the snapshot states to the FSM encoding.
package timer_seq_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_RUN_WORD =
    16'((1 << CTRL_START) | (1 << CTRL_CONT) | (1 << CTRL_ITO));
  localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_RD_STAT,
    ST_WAIT_RD,
    ST_CLR_STAT,
    ST_WR_STOP,
    ST_DONE
`ifdef TIMER_SNAPSHOT_EN
    ,
    ST_SNAP_WR,
    ST_SNAP_RDL,
    ST_SNAP_RDH,
    ST_SNAP_WAIT
`endif
  } state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_req_t;

  function automatic bus_req_t bus_wr(input logic [2:0] a,
                                      input logic [15:0] d);
    bus_wr = '{req: 1'b1, we: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic bus_req_t bus_rd(input logic [2:0] a);
    bus_rd = '{req: 1'b1, we: 1'b0, addr: a, wdata: 16'h0000};
  endfunction

endpackage

// File: rtl/timer_cfg_sequencer_bus_master.sv
// timer_bus_master: registered single-cycle Avalon-MM access driver.
// Read data is flagged valid in the cycle after the read strobe.
module timer_bus_master
  import timer_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  bus_req_t    i_req,
  output logic        o_rvalid,
  output logic [15:0] o_rdata,
  output logic [2:0]  o_avm_address,
  output logic        o_avm_chipselect,
  output logic        o_avm_write_n,
  output logic [15:0] o_avm_writedata,
  input  logic [15:0] i_avm_readdata
);

  logic [2:0]  r_addr;
  logic        r_cs;
  logic        r_write_n;
  logic [15:0] r_wdata;
  logic        r_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_wdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_cs      <= i_req.req;
      r_write_n <= !(i_req.req && i_req.we);
      r_rvalid  <= r_cs && r_write_n;
      if (i_req.req) begin
        r_addr  <= i_req.addr;
        r_wdata <= i_req.we ? i_req.wdata : 16'h0000;
      end
    end
  end

  assign o_avm_address    = r_addr;
  assign o_avm_chipselect = r_cs;
  assign o_avm_write_n    = r_write_n;
  assign o_avm_writedata  = r_wdata;
  assign o_rvalid         = r_rvalid;
  assign o_rdata          = i_avm_readdata;

endmodule

// File: rtl/timer_cfg_sequencer.sv
// timer_cfg_sequencer: programs the interval timer, services its IRQ.
// Define TIMER_SNAPSHOT_EN to add the counter snapshot request path.
module timer_cfg_sequencer
  import timer_seq_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] MIN_PERIOD = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_stop,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] tick_count,
`ifdef TIMER_SNAPSHOT_EN
  input  logic             snap_req,
  output logic [31:0]      snap_value,
  output logic             snap_valid,
`endif
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             timer_irq
);

  state_e           r_state;
  state_e           w_next;
  logic [31:0]      r_period;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_tick_count;
  logic             r_stop;
  logic [31:0]      w_period_cl;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  bus_req_t         w_req;
  logic             w_rvalid;
  logic [15:0]      w_rdata;

  assign w_period_cl = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  assign w_cnt_inc   = r_tick_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last      = (r_count != '0) && (w_cnt_inc == r_count);

`ifdef TIMER_SNAPSHOT_EN
  logic        r_snap_pend;
  logic [15:0] r_snap_lo;
  logic [31:0] r_snap_value;
  logic        r_snap_valid;
`else
  logic w_unused_rd;
  assign w_unused_rd = &{1'b0, w_rdata};
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (cmd_valid) w_next = ST_WR_PL;
      ST_WR_PL:    w_next = ST_WR_PH;
      ST_WR_PH:    w_next = ST_WR_CTRL;
      ST_WR_CTRL:  w_next = ST_RUN;
      ST_RUN: begin
        if (timer_irq) w_next = ST_RD_STAT;
`ifdef TIMER_SNAPSHOT_EN
        else if (r_snap_pend) w_next = ST_SNAP_WR;
`endif
        else if (r_stop) w_next = ST_WR_STOP;
      end
      ST_RD_STAT:  w_next = ST_WAIT_RD;
      // status bit 0 clear means the IRQ was spurious
      ST_WAIT_RD:  w_next = (w_rvalid && w_rdata[0]) ? ST_CLR_STAT : ST_RUN;
      ST_CLR_STAT: w_next = (w_last || r_stop) ? ST_WR_STOP : ST_RUN;
      ST_WR_STOP:  w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
`ifdef TIMER_SNAPSHOT_EN
      ST_SNAP_WR:   w_next = ST_SNAP_RDL;
      ST_SNAP_RDL:  w_next = ST_SNAP_RDH;
      ST_SNAP_RDH:  w_next = ST_SNAP_WAIT;
      ST_SNAP_WAIT: w_next = ST_RUN;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  // bus outputs are registered, so the access is issued for the next state
  always_comb begin
    w_req = '0;
    unique case (w_next)
      ST_WR_PL:    w_req = bus_wr(TMR_PERIODL, w_period_cl[15:0]);
      ST_WR_PH:    w_req = bus_wr(TMR_PERIODH, r_period[31:16]);
      ST_WR_CTRL:  w_req = bus_wr(TMR_CONTROL, CTRL_RUN_WORD);
      ST_RD_STAT:  w_req = bus_rd(TMR_STATUS);
      ST_CLR_STAT: w_req = bus_wr(TMR_STATUS, 16'h0000);
      ST_WR_STOP:  w_req = bus_wr(TMR_CONTROL, CTRL_STOP_WORD);
`ifdef TIMER_SNAPSHOT_EN
      ST_SNAP_WR:  w_req = bus_wr(TMR_SNAPL, 16'h0000);
      ST_SNAP_RDL: w_req = bus_rd(TMR_SNAPL);
      ST_SNAP_RDH: w_req = bus_rd(TMR_SNAPH);
`endif
      default:     w_req = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_period     <= '0;
      r_count      <= '0;
      r_tick_count <= '0;
      r_stop       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_period     <= w_period_cl;
        r_count      <= cmd_count;
        r_tick_count <= '0;
      end
      if (r_state == ST_CLR_STAT) r_tick_count <= w_cnt_inc;
      if (r_state == ST_DONE) r_stop <= 1'b0;
      else if (cmd_stop && r_state != ST_IDLE) r_stop <= 1'b1;
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_pend  <= 1'b0;
      r_snap_lo    <= '0;
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
      if (r_state == ST_DONE || w_next == ST_SNAP_WR) r_snap_pend <= 1'b0;
      else if (snap_req && r_state != ST_IDLE) r_snap_pend <= 1'b1;
      if (r_state == ST_SNAP_RDH && w_rvalid) r_snap_lo <= w_rdata;
      if (r_state == ST_SNAP_WAIT && w_rvalid) begin
        r_snap_value <= {w_rdata, r_snap_lo};
        r_snap_valid <= 1'b1;
      end
    end
  end

  assign snap_value = r_snap_value;
  assign snap_valid = r_snap_valid;
`endif

  timer_bus_master u_bus (
    .clk              (clk),
    .reset            (reset),
    .i_req            (w_req),
    .o_rvalid         (w_rvalid),
    .o_rdata          (w_rdata),
    .o_avm_address    (avm_address),
    .o_avm_chipselect (avm_chipselect),
    .o_avm_write_n    (avm_write_n),
    .o_avm_writedata  (avm_writedata),
    .i_avm_readdata   (avm_readdata)
  );

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign tick       = (r_state == ST_CLR_STAT);
  assign done       = (r_state == ST_DONE);
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// tb_timer_cfg_sequencer: table, directed and random checks against a
// behavioural interval-timer model and expected bus-transaction lists.
module tb_timer_cfg_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_period = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_stop = 1'b0;
  logic             busy, tick, done;
  logic [CNT_W-1:0] tick_count;
  logic [2:0]       avm_address;
  logic             avm_chipselect, avm_write_n;
  logic [15:0]      avm_writedata;
  logic [15:0]      avm_readdata = '0;
  logic             timer_irq;
`ifdef TIMER_SNAPSHOT_EN
  logic             snap_req = 1'b0;
  logic [31:0]      snap_value;
  logic             snap_valid;
`endif

  timer_cfg_sequencer #(.CNT_W(CNT_W), .MIN_PERIOD(32'd1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_count(cmd_count),
    .cmd_stop(cmd_stop), .busy(busy), .tick(tick), .done(done),
    .tick_count(tick_count),
`ifdef TIMER_SNAPSHOT_EN
    .snap_req(snap_req), .snap_value(snap_value),
    .snap_valid(snap_valid),
`endif
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // interval timer model: auto mode counts down, manual mode is scripted
  logic        auto_m = 1'b0;
  logic        man_irq = 1'b0;
  logic        man_to = 1'b0;
  logic [31:0] man_snap = '0;
  logic        m_run = 1'b0;
  logic        m_to = 1'b0;
  logic [31:0] m_per = '0;
  logic [31:0] m_cnt = '0;

  assign timer_irq = auto_m ? m_to : man_irq;

  always @(posedge clk) begin
    if (m_run) begin
      if (m_cnt <= 1) begin
        m_to  <= 1'b1;
        m_cnt <= m_per;
      end else m_cnt <= m_cnt - 1;
    end
    if (avm_chipselect && !avm_write_n) begin
      case (avm_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          if (avm_writedata[2]) begin
            m_run <= 1'b1; m_cnt <= m_per; m_to <= 1'b0;
          end else if (avm_writedata[3]) m_run <= 1'b0;
        end
        3'd2: m_per[15:0]  <= avm_writedata;
        3'd3: m_per[31:16] <= avm_writedata;
        default: ;
      endcase
    end
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        3'd0: avm_readdata <= {15'd0, auto_m ? m_to : man_to};
        3'd4: avm_readdata <= man_snap[15:0];
        3'd5: avm_readdata <= man_snap[31:16];
        default: avm_readdata <= 16'hDEAD;
      endcase
    end
  end

  // bus and pulse monitor
  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
    int unsigned cyc;
  } acc_t;
  acc_t log_q[$];
  int n_tick = 0, n_done = 0, n_tick_bad = 0, n_snapv = 0;
  logic [31:0] last_snap = '0;

  always @(negedge clk) begin
    acc_t e;
    if (avm_chipselect) begin
      e.addr = avm_address; e.wr = !avm_write_n;
      e.data = avm_writedata; e.cyc = cyc;
      log_q.push_back(e);
    end
    if (tick) begin
      n_tick++;
      if (!(avm_chipselect && !avm_write_n && avm_address == 3'd0
            && avm_writedata == 16'h0)) n_tick_bad++;
    end
    if (done) n_done++;
`ifdef TIMER_SNAPSHOT_EN
    if (snap_valid) begin n_snapv++; last_snap = snap_value; end
`endif
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
  } exp_t;
  exp_t eq[$];

  task automatic push_acc(input logic [2:0] a, input logic w,
                          input logic [15:0] d);
    exp_t x;
    x.addr = a; x.wr = w; x.data = d;
    eq.push_back(x);
  endtask

  // expected traffic of a full counted run, built from the register map
  task automatic build_run(input logic [31:0] p, input int c);
    logic [31:0] pc;
    pc = (p < 32'd1) ? 32'd1 : p;
    eq.delete();
    push_acc(3'd2, 1'b1, pc[15:0]);
    push_acc(3'd3, 1'b1, pc[31:16]);
    push_acc(3'd1, 1'b1, 16'h0007);
    for (int i = 0; i < c; i++) begin
      push_acc(3'd0, 1'b0, 16'h0);
      push_acc(3'd0, 1'b1, 16'h0000);
    end
    push_acc(3'd1, 1'b1, 16'h0008);
  endtask

  task automatic cmp_trace(input string nm, input int base);
    acc_t a;
    check({nm, "_len"}, 32'(log_q.size() - base), 32'(eq.size()));
    for (int i = 0; i < eq.size() && base + i < log_q.size(); i++) begin
      a = log_q[base + i];
      check(nm, 32'({a.addr, a.wr, a.wr ? a.data : 16'h0}),
            32'({eq[i].addr, eq[i].wr, eq[i].wr ? eq[i].data : 16'h0}));
    end
  endtask

  task automatic start_cmd(input logic [31:0] p, input logic [15:0] c,
                           output int unsigned acc, output int base);
    base = log_q.size();
    cmd_period = p; cmd_count = c; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
  endtask

  task automatic irq_once(input logic st);
    man_to = st; man_irq = 1'b1; step(); man_irq = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    repeat (3) step();
    check({nm, "_done_once"}, 32'(n_done - d0), 32'd1);
  endtask

  typedef struct {
    logic [31:0] period;
    logic [15:0] count;
    logic [15:0] exp_pl;
    logic [15:0] exp_ph;
    int          exp_ticks;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int unsigned acc;
    int base, t0, bad0;
    acc_t a;
    logic [31:0] rp;
    int rc;

    tbl[0] = '{32'd9,  16'd3, 16'h0009, 16'h0000, 3};
    tbl[1] = '{32'd0,  16'd2, 16'h0001, 16'h0000, 2};
    tbl[2] = '{32'd14, 16'd1, 16'h000E, 16'h0000, 1};
    tbl[3] = '{32'd5,  16'd4, 16'h0005, 16'h0000, 4};

    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", 32'(avm_writedata), 32'd0);
    check("rst_tick_done", 32'({tick, done}), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);

    // programming sequence and its latency
    start_cmd(32'h0001_0005, 16'd0, acc, base);
    check("prog_busy", 32'({busy, cmd_ready}), 32'b10);
    repeat (6) step();
    eq.delete();
    push_acc(3'd2, 1'b1, 16'h0005);
    push_acc(3'd3, 1'b1, 16'h0001);
    push_acc(3'd1, 1'b1, 16'h0007);
    cmp_trace("prog", base);
    for (int i = 0; i < 3 && base + i < log_q.size(); i++)
      check("prog_cycle", log_q[base + i].cyc - acc, 32'(i));
    pulse_stop();
    wait_done("prog_stop", 20);
    push_acc(3'd1, 1'b1, 16'h0008);
    cmp_trace("prog_stop", base);
    check("prog_ticks", 32'(tick_count), 32'd0);

    // spurious irq, then a genuine one
    start_cmd(32'd9, 16'd0, acc, base);
    repeat (4) step();
    t0 = n_tick;
    irq_once(1'b0);
    repeat (5) step();
    check("spur_len", 32'(log_q.size() - base), 32'd4);
    a = log_q[log_q.size() - 1];
    check("spur_read", 32'({a.addr, a.wr}), 32'({3'd0, 1'b0}));
    check("spur_ticks", 32'(n_tick - t0), 32'd0);
    check("spur_count", 32'(tick_count), 32'd0);
    irq_once(1'b1);
    repeat (5) step();
    check("spur_rearm_ticks", 32'(n_tick - t0), 32'd1);
    check("spur_rearm_count", 32'(tick_count), 32'd1);
    man_to = 1'b0;
    pulse_stop();
    wait_done("spur", 20);

    // stop during WR_PH
    start_cmd(32'd9, 16'd0, acc, base);
    step();
    pulse_stop();
    wait_done("stop_ph", 20);
    eq.delete();
    push_acc(3'd2, 1'b1, 16'h0009);
    push_acc(3'd3, 1'b1, 16'h0000);
    push_acc(3'd1, 1'b1, 16'h0007);
    push_acc(3'd1, 1'b1, 16'h0008);
    cmp_trace("stop_ph", base);
    if (log_q.size() >= base + 4)
      check("stop_ph_cycle", log_q[base + 3].cyc - acc, 32'd4);
    check("stop_ph_count", 32'(tick_count), 32'd0);

    // stop and irq in the same RUN cycle
    start_cmd(32'd9, 16'd0, acc, base);
    repeat (4) step();
    t0 = n_tick;
    cmd_stop = 1'b1;
    irq_once(1'b1);
    cmd_stop = 1'b0;
    wait_done("stop_irq", 20);
    man_to = 1'b0;
    build_run(32'd9, 1);
    cmp_trace("stop_irq", base);
    check("stop_irq_ticks", 32'(n_tick - t0), 32'd1);
    check("stop_irq_count", 32'(tick_count), 32'd1);

    // reset while waiting for status read data
    start_cmd(32'd9, 16'd0, acc, base);
    repeat (4) step();
    irq_once(1'b1);
    repeat (4) step();
    check("rstmid_pre_count", 32'(tick_count), 32'd1);
    t0 = n_tick;
    irq_once(1'b1);
    step();
    reset = 1'b1;
    step();
    check("rstmid_cs", 32'(avm_chipselect), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_count", 32'(tick_count), 32'd0);
    check("rstmid_no_tick", 32'(n_tick - t0), 32'd0);
    reset = 1'b0;
    man_to = 1'b0;
    step();
    start_cmd(32'h0000_0021, 16'd0, acc, base);
    repeat (4) step();
    pulse_stop();
    wait_done("rstmid_reprog", 20);
    eq.delete();
    push_acc(3'd2, 1'b1, 16'h0021);
    push_acc(3'd3, 1'b1, 16'h0000);
    push_acc(3'd1, 1'b1, 16'h0007);
    push_acc(3'd1, 1'b1, 16'h0008);
    cmp_trace("rstmid_reprog", base);

`ifdef TIMER_SNAPSHOT_EN
    t0 = n_snapv;
    snap_req = 1'b1; step(); snap_req = 1'b0;
    repeat (2) step();
    check("snap_idle_drop", 32'(n_snapv - t0), 32'd0);
    start_cmd(32'd9, 16'd0, acc, base);
    repeat (4) step();
    man_snap = 32'h0000_0042;
    snap_req = 1'b1; step(); snap_req = 1'b0;
    for (int i = 0; i < 20 && n_snapv == t0; i++) step();
    repeat (3) step();
    check("snap_valid_once", 32'(n_snapv - t0), 32'd1);
    check("snap_value", last_snap, 32'h0000_0042);
    pulse_stop();
    wait_done("snap", 20);
    eq.delete();
    push_acc(3'd2, 1'b1, 16'h0009);
    push_acc(3'd3, 1'b1, 16'h0000);
    push_acc(3'd1, 1'b1, 16'h0007);
    push_acc(3'd4, 1'b1, 16'h0000);
    push_acc(3'd4, 1'b0, 16'h0000);
    push_acc(3'd5, 1'b0, 16'h0000);
    push_acc(3'd1, 1'b1, 16'h0008);
    cmp_trace("snap", base);
`endif

    // table-driven counted runs against the timer model
    auto_m = 1'b1;
    foreach (tbl[k]) begin
      t0 = n_tick; bad0 = n_tick_bad;
      start_cmd(tbl[k].period, tbl[k].count, acc, base);
      wait_done("tbl", 400);
      if (log_q.size() >= base + 2) begin
        check("tbl_pl", 32'(log_q[base].data), 32'(tbl[k].exp_pl));
        check("tbl_ph", 32'(log_q[base + 1].data), 32'(tbl[k].exp_ph));
      end else check("tbl_prog_seen", 32'(log_q.size() - base), 32'd2);
      check("tbl_ticks", 32'(n_tick - t0), 32'(tbl[k].exp_ticks));
      check("tbl_count", 32'(tick_count), 32'(tbl[k].count));
      check("tbl_tick_clear", 32'(n_tick_bad - bad0), 32'd0);
      a = log_q[log_q.size() - 1];
      check("tbl_stop_wr", 32'({a.addr, a.wr, a.data}),
            32'({3'd1, 1'b1, 16'h0008}));
      check("tbl_idle", 32'(cmd_ready), 32'd1);
    end

    // randomized counted runs against the expected-traffic model
    for (int r = 0; r < 6; r++) begin
      rp = 32'($urandom_range(24, 3));
      rc = int'($urandom_range(6, 1));
      t0 = n_tick;
      start_cmd(rp, 16'(rc), acc, base);
      wait_done("rnd", 400);
      build_run(rp, rc);
      cmp_trace("rnd", base);
      check("rnd_ticks", 32'(n_tick - t0), 32'(rc));
      check("rnd_count", 32'(tick_count), 32'(rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
